// File: rtl/delay_calc.sv
// delay_calc: per-channel receive-delay engine.
// On an accepted start it latches the focal point, then for each channel
// reads the element coordinates from the ROM, squares the distance
// components, and takes a bit-serial integer square root. It emits
// focus_z + floor(distance) over a valid/ready stream.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               frame request (sampled only in IDLE)
//   focus_x, focus_z    focal point, latched on accepted start
//   rom_addr            channel index to the coordinate ROM
//   rom_x, rom_z        element coordinates (combinational ROM read)
//   delay_valid/ready   output stream handshake
//   delay_out           focus_z + floor(sqrt(dx^2 + dz^2)), 18 bits
//   delay_ch            channel the delay belongs to
//   busy                high from the cycle after start through DONE
//   done                one-cycle pulse after the last channel handshake
module delay_calc #(
  parameter int NUM_CHANNELS = 16,
  parameter int ADDR_WIDTH   = $clog2(NUM_CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [15:0]           focus_x,
  input  logic [15:0]           focus_z,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [15:0]           rom_x,
  input  logic [15:0]           rom_z,
  output logic                  delay_valid,
  input  logic                  delay_ready,
  output logic [17:0]           delay_out,
  output logic [ADDR_WIDTH-1:0] delay_ch,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {IDLE, FETCH, SQUARE, SQRT, OUT, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_CH   = ADDR_WIDTH'(NUM_CHANNELS - 1);
  localparam logic [4:0]            SQRT_LAST = 5'd16;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] ch;
  logic [15:0] fx_l, fz_l;
  logic [15:0] dx, dz;
  logic [33:0] rad;
  logic [19:0] rem;
  logic [16:0] root;
  logic [4:0]  sq_cnt;

  logic [32:0] dx_w, dz_w, sq_sum;
  logic [21:0] rem_sh, trial;
  logic        fits;
  logic [16:0] root_nxt;

  assign rom_addr = ch;
  assign delay_ch = ch;

  // Restoring sqrt step: bring down the next two radicand bits and try
  // subtracting 4*root+1; success sets the next root bit.
  always_comb begin
    dx_w     = 33'(dx);
    dz_w     = 33'(dz);
    sq_sum   = dx_w * dx_w + dz_w * dz_w;
    rem_sh   = {rem, rad[33:32]};
    trial    = {3'b000, root, 2'b01};
    fits     = (rem_sh >= trial);
    root_nxt = {root[15:0], fits};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   state_nxt = SQUARE;
      SQUARE:  state_nxt = SQRT;
      SQRT:    if (sq_cnt == SQRT_LAST) state_nxt = OUT;
      OUT:     if (delay_ready) state_nxt = (ch == LAST_CH) ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    delay_valid = (state == OUT);
    done        = (state == DONE);
    busy        = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch        <= '0;
      fx_l      <= '0;
      fz_l      <= '0;
      dx        <= '0;
      dz        <= '0;
      rad       <= '0;
      rem       <= '0;
      root      <= '0;
      sq_cnt    <= '0;
      delay_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            fx_l <= focus_x;
            fz_l <= focus_z;
            ch   <= '0;
          end
        end
        FETCH: begin
          dx <= (fx_l >= rom_x) ? fx_l - rom_x : rom_x - fx_l;
          dz <= (fz_l >= rom_z) ? fz_l - rom_z : rom_z - fz_l;
        end
        SQUARE: begin
          rad    <= {1'b0, sq_sum};
          rem    <= '0;
          root   <= '0;
          sq_cnt <= '0;
        end
        SQRT: begin
          rad    <= {rad[31:0], 2'b00};
          rem    <= fits ? 20'(rem_sh - trial) : rem_sh[19:0];
          root   <= root_nxt;
          sq_cnt <= sq_cnt + 5'd1;
          // Final root bit is known this cycle, so the result is ready on entry to OUT.
          if (sq_cnt == SQRT_LAST)
            delay_out <= {2'b00, fz_l} + {1'b0, root_nxt};
        end
        OUT: begin
          if (delay_ready && ch != LAST_CH) ch <= ch + ADDR_WIDTH'(1);
        end
        DONE: ch <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_calc.sv
module tb_delay_calc;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] focus_x, focus_z;
  logic [3:0]  rom_addr;
  logic [15:0] rom_x, rom_z;
  logic        delay_valid, delay_ready;
  logic [17:0] delay_out;
  logic [3:0]  delay_ch;
  logic        busy, done;

  logic [15:0] tab_x [N];
  logic [15:0] tab_z [N];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rom_x = tab_x[rom_addr];
  assign rom_z = tab_z[rom_addr];

  delay_calc #(.NUM_CHANNELS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .focus_x(focus_x), .focus_z(focus_z),
    .rom_addr(rom_addr), .rom_x(rom_x), .rom_z(rom_z),
    .delay_valid(delay_valid), .delay_ready(delay_ready),
    .delay_out(delay_out), .delay_ch(delay_ch),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint ref_delay(longint fx, longint fz, longint x, longint z);
    longint dx, dz, s, r;
    dx = (fx > x) ? fx - x : x - fx;
    dz = (fz > z) ? fz - z : z - fz;
    s  = dx * dx + dz * dz;
    r  = longint'($sqrt(real'(s)));
    while (r * r > s) r--;
    while ((r + 1) * (r + 1) <= s) r++;
    return fz + r;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_valid"},    delay_valid, 0);
    chk({tag, "_out"},      delay_out, 0);
    chk({tag, "_ch"},       delay_ch, 0);
    chk({tag, "_busy"},     busy, 0);
    chk({tag, "_done"},     done, 0);
  endtask

  task automatic set_basic_rom();
    for (int i = 0; i < N; i++) begin
      tab_x[i] = 16'd0;
      tab_z[i] = 16'd0;
    end
    tab_x[0] = 16'd11; tab_x[1] = 16'd2; tab_x[2] = 16'd2; tab_x[3] = 16'd11;
  endtask

  // Runs one frame starting at the current negedge. Cycle k is the k-th
  // cycle after the edge that samples start.
  task automatic run_frame(input logic [15:0] fx, input logic [15:0] fz, input bit hold,
                           input int stall_ch, input int stall_len, input bit rnd_ready,
                           input int restart_k, input int rst_k);
    longint exp_d [N];
    int idx = 0, k = 0, stalls = 0, stall_left = stall_len;
    bit prev_wait = 1'b0, seen_valid = 1'b0, fin = 1'b0, rdy;
    logic [17:0] prev_out = '0;
    logic [3:0]  prev_ch = '0;
    for (int i = 0; i < N; i++) exp_d[i] = ref_delay(fx, fz, tab_x[i], tab_z[i]);
    focus_x = fx; focus_z = fz; start = 1'b1; delay_ready = 1'b1;
    while (!fin) begin
      @(negedge clk);
      k++;
      start = hold || (k == restart_k);
      if (k == restart_k) begin focus_x = 16'd0; focus_z = 16'd0; end
      if (k > 4000) begin
        checks++; errors++;
        $error("FAIL timeout observed=%0d expected=done", k);
        fin = 1'b1;
      end else if (rst_k > 0 && k == rst_k + 1) begin
        chk_reset_vals("midreset");
        rst_n = 1'b1;
      end else if (rst_k > 0 && k > rst_k + 1) begin
        chk("postreset_valid", delay_valid, 0);
        chk("postreset_done", done, 0);
        if (k == rst_k + 60) fin = 1'b1;
      end else begin
        if (rst_k > 0 && k == rst_k) rst_n = 1'b0;
        chk("busy", busy, 1);
        chk("valid_done_excl", delay_valid & done, 0);
        if (idx < N) chk("rom_addr", rom_addr, idx);
        if (prev_wait) begin
          chk("held_valid", delay_valid, 1);
          chk("held_out", delay_out, prev_out);
          chk("held_ch", delay_ch, prev_ch);
        end
        if (delay_valid && idx < N) begin
          if (!seen_valid) chk("first_valid_cycle", k, 20);
          seen_valid = 1'b1;
          chk("delay_ch", delay_ch, idx);
          chk("delay_out", delay_out, exp_d[idx]);
          if (rnd_ready) rdy = ($urandom_range(0, 2) != 0);
          else if (idx == stall_ch && stall_left > 0) begin rdy = 1'b0; stall_left--; end
          else rdy = 1'b1;
          delay_ready = rdy;
          if (!rdy) stalls++;
          prev_wait = !rdy;
          prev_out  = delay_out;
          prev_ch   = delay_ch;
          if (rdy && !(rst_k > 0 && k == rst_k)) idx++;
        end else begin
          prev_wait = 1'b0;
          delay_ready = rnd_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
        end
        if (done) begin
          chk("done_cycle", k, 20 * N + stalls + 1);
          chk("done_all_channels", idx, N);
          @(negedge clk);
          start = hold;
          chk("idle_busy", busy, 0);
          chk("idle_done", done, 0);
          chk("idle_valid", delay_valid, 0);
          chk("idle_rom_addr", rom_addr, 0);
          fin = 1'b1;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; focus_x = '0; focus_z = '0; delay_ready = 1'b0;
    set_basic_rom();
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame, then backpressure on ch2, then start while busy.
    run_frame(16'd5, 16'd8, 1'b0, -1, 0, 1'b0, 0, 0);
    run_frame(16'd5, 16'd8, 1'b0, 2, 5, 1'b0, 0, 0);
    run_frame(16'd5, 16'd8, 1'b0, -1, 0, 1'b0, 50, 0);

    // Mid-frame reset, then a clean frame must match the basic sequence.
    run_frame(16'd5, 16'd8, 1'b0, -1, 0, 1'b0, 0, 100);
    run_frame(16'd5, 16'd8, 1'b0, -1, 0, 1'b0, 0, 0);

    // Extremes.
    for (int i = 0; i < N; i++) tab_x[i] = 16'd0;
    run_frame(16'hFFFF, 16'hFFFF, 1'b0, -1, 0, 1'b0, 0, 0);
    set_basic_rom();
    run_frame(16'd0, 16'd0, 1'b0, -1, 0, 1'b0, 0, 0);

    // Back-to-back frames with start held high.
    for (int f = 0; f < 3; f++) run_frame(16'd5, 16'd8, 1'b1, -1, 0, 1'b0, 0, 0);
    start = 1'b0;
    @(negedge clk);

    // Randomized ROM contents, focus and ready.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++) begin
        tab_x[i] = 16'($urandom);
        tab_z[i] = 16'($urandom);
      end
      run_frame(16'($urandom), 16'($urandom), 1'b0, -1, 0, 1'b1, 0, 0);
    end

    repeat (5) @(negedge clk);
    chk("final_busy", busy, 0);
    chk("final_valid", delay_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/delay_calc.md
# delay_calc

Per-channel receive-delay engine for the beamformer. On `start` it walks every channel. For each one it:
- drives the channel index to the element-coordinate ROM and reads back `(x, z)` combinationally in the same cycle;
- computes the Euclidean distance from that element to the latched focal point with a bit-serial integer square root;
- emits `delay = focus_z + distance`, in sample units, over a valid/ready stream to the delay-line / sample-fetch stage.

It sits directly downstream of the coordinate ROM and upstream of the sample-fetch stage.

## Interface
Parameters:
- `NUM_CHANNELS`, default 16: number of channels (ROM entries) walked per frame.
- `ADDR_WIDTH`, default `$clog2(NUM_CHANNELS)`: width of the ROM address and the channel index.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: frame request; sampled only in IDLE.
- `focus_x`, in, 16: focal x, unsigned; latched on accepted `start`.
- `focus_z`, in, 16: focal z, unsigned; latched on accepted `start`.
- `rom_addr`, out, ADDR_WIDTH: channel index to the coordinate ROM.
- `rom_x`, in, 16: element x from the ROM, valid in the same cycle as `rom_addr`.
- `rom_z`, in, 16: element z from the ROM, valid in the same cycle as `rom_addr`.
- `delay_valid`, out, 1: `delay_out` / `delay_ch` valid.
- `delay_ready`, in, 1: downstream accepts.
- `delay_out`, out, 18: `focus_z + floor(sqrt(dx² + dz²))`.
- `delay_ch`, out, ADDR_WIDTH: channel the delay belongs to.
- `busy`, out, 1: high from the cycle after an accepted `start` through the DONE cycle.
- `done`, out, 1: one-cycle pulse after the last channel's handshake.

## Operation
- FSM states: IDLE, FETCH, SQUARE, SQRT, OUT, DONE.
- IDLE → FETCH when `start` = 1. On that edge: latch `focus_x` / `focus_z` and set `ch` = 0.
- FETCH, 1 cycle:
  - `rom_addr` = `ch`.
  - Register `dx = |focus_x − rom_x|` and `dz = |focus_z − rom_z|`, both 16-bit unsigned magnitudes.
- SQUARE, 1 cycle: register `sum = dx·dx + dz·dz`, 33 bits, no truncation.
- SQRT, exactly 17 cycles: restoring bit-serial sqrt of `sum`, zero-extended to 34 bits. Produces a 17-bit floor root; one result bit per cycle, MSB first.
- OUT:
  - `delay_valid` = 1, `delay_out = focus_z + root`, zero-extended to 18 bits. The worst case of 158215 fits, so no overflow.
  - `delay_out` and `delay_ch` are held stable while `delay_ready` = 0.
  - On `delay_valid & delay_ready`: if `ch == NUM_CHANNELS−1`, go to DONE; else `ch++` and go to FETCH.
- DONE, 1 cycle: `done` = 1, then go to IDLE.
- `rom_addr` always equals `ch` (0 in IDLE).
- `start` outside IDLE is ignored.
- Changes to `focus_x` / `focus_z` after latching have no effect until the next accepted `start`.
- Reset: `rst_n` = 0 at any edge forces IDLE. Mid-frame reset abandons the frame: no further `delay_valid`, no `done`.

## Timing
- Reset values: `rom_addr` = 0, `delay_valid` = 0, `delay_out` = 0, `delay_ch` = 0, `busy` = 0, `done` = 0.
- `start` sampled at edge E0:
  - FETCH in cycle 1, SQUARE in cycle 2, SQRT in cycles 3–19.
  - `delay_valid` first high in cycle 20.
- With `delay_ready` tied high:
  - Each channel takes 20 cycles.
  - Last handshake in cycle 20·NUM_CHANNELS (320 at default).
  - `done` pulses in cycle 321; `busy` falls the following cycle.
- Each stalled cycle with `delay_valid` high and `delay_ready` low adds exactly one cycle.
- `delay_valid` never drops without a handshake, except on reset.
- `done` and `delay_valid` are never high in the same cycle.

## Test plan
Bench ROM model: x = {11,2,2,11,0,…,0}, z = all 0. Default parameters.

- **Basic frame.** Focus (5,8), `delay_ready` = 1, `start` pulse → in order:
  - ch0 = 18, ch1 = 16, ch2 = 16, ch3 = 18, ch4–ch15 = 17.
  - First valid 20 cycles after `start`, `done` at cycle 321, `busy` low afterwards.
- **Backpressure.** Drop `delay_ready` for 5 cycles while ch2 is valid → `delay_out` = 16 and `delay_ch` = 2 held stable. `done` moves to cycle 326.
- **Extremes.** Focus (0xFFFF, 0xFFFF), ROM forced all 0 → every delay = 158215. Focus (0,0) → every `rom_x` − 0 path yields delay = `rom_x` (ch0 = 11, ch4 = 0).
- **Start while busy.** Second `start` at cycle 50 with focus (0,0) → ignored; the frame still produces the basic-frame values.
- **Reset mid-frame.** `rst_n` = 0 at cycle 100 for one edge → all outputs at reset values next cycle, no `done`. A new `start` then reproduces the basic-frame sequence exactly.
- **Back-to-back frames.** `start` held high continuously → a new frame begins the cycle after each DONE (IDLE for one cycle), and each frame is identical.
